// File: rtl/router_pkg.sv
// Shared definitions for the router port reader: header field layout,
// reader FSM states and router timing constants.
package router_pkg;

   // Header byte layout: {len[7:2], addr[1:0]}
   localparam int LEN_MSB  = 7;
   localparam int LEN_LSB  = 2;
   localparam int ADDR_MSB = 1;
   localparam int ADDR_LSB = 0;

   // Router soft-resets a port FIFO that is left unread this many cycles
   localparam int SOFT_RESET_CYCLES = 30;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      HDR_WAIT = 3'd1,
      BODY     = 3'd2,
      ABORT    = 3'd3,
      DRAIN    = 3'd4
   } rd_state_e;

   function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
      return hdr[LEN_MSB:LEN_LSB];
   endfunction

   function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
      return hdr[ADDR_MSB:ADDR_LSB];
   endfunction

endpackage

// File: rtl/router_reader_buf.sv
// Two-entry output buffer for the port reader. Each entry carries
// {last, first, err, data}. Push and pop may share a cycle even when full.
module router_reader_buf #(
   parameter int W = 11
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);

   logic [1:0][W-1:0] mem_q;
   logic              wptr_q;
   logic              rptr_q;
   logic [1:0]        cnt_q;
   logic              do_push;
   logic              do_pop;

   assign do_pop  = pop & (cnt_q != 2'd0);
   assign do_push = push & ((cnt_q != 2'd2) | do_pop);

   assign rdata = mem_q[rptr_q];
   assign full  = (cnt_q == 2'd2);
   assign empty = (cnt_q == 2'd0);
   assign count = cnt_q;

   // Storage, pointers and occupancy
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         mem_q  <= '0;
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
         cnt_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= wdata;
            wptr_q        <= ~wptr_q;
         end
         if (do_pop)
            rptr_q <= ~rptr_q;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/router_port_reader.sv
// Destination-side reader for one router output port. Pops header,
// payload and parity from the port FIFO and re-emits them as a
// valid/ready byte stream with first/last/err markers.
// Optional: define ROUTER_READER_PARITY_CHECK_EN to check the parity byte.
module router_port_reader
   import router_pkg::*;
#(
   parameter int         DATA_W    = 8,
   parameter logic [1:0] PORT_ADDR = 2'b00,
   parameter int         STALL_MAX = 32,
   parameter int         CNT_W     = 16
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              vld_out,
   input  logic [DATA_W-1:0] data_out,
   output logic              read_enb,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_first,
   output logic              m_last,
   output logic              m_err,
   output logic              busy,
   output logic [CNT_W-1:0]  pkt_cnt,
   output logic [7:0]        err_cnt
);

   localparam int BW = DATA_W + 3;
   localparam int SW = $clog2(STALL_MAX + 1);

   rd_state_e         state_q;
   logic [6:0]        rd_left_q;     // reads still to issue (len + parity)
   logic              rd_pend_q;     // a read issued last cycle returns now
   logic              last_pend_q;   // that returning read is the parity byte
   logic [SW-1:0]     stall_q;
   logic [1:0]        addr_q;
   logic [CNT_W-1:0]  pkt_cnt_q;
   logic [7:0]        err_cnt_q;

   logic              buf_push;
   logic [BW-1:0]     buf_wdata;
   logic              buf_pop;
   logic [BW-1:0]     buf_rdata;
   logic              buf_full;
   logic              buf_empty;
   logic [1:0]        buf_cnt;

   logic [7:0]        hdr;
   logic              can_rd;
   logic              addr_bad;
   logic              last_err;
   logic              acc_last;

   assign hdr = data_out[7:0];

   // One free slot must remain for every read still in flight
   assign can_rd = ({1'b0, buf_cnt} + {2'b00, rd_pend_q}) < 3'd2;

   // Reset gates the request so it drops immediately, not at the next edge
   assign read_enb = resetn & vld_out & can_rd &
                     ((state_q == IDLE) | ((state_q == BODY) & (rd_left_q != 7'd0)));

   assign addr_bad = (addr_q != PORT_ADDR);

`ifdef ROUTER_READER_PARITY_CHECK_EN
   logic [DATA_W-1:0] par_q;

   // Running XOR over header and payload; parity byte itself is excluded
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         par_q <= '0;
      else if (state_q == HDR_WAIT)
         par_q <= data_out;
      else if (rd_pend_q && !last_pend_q)
         par_q <= par_q ^ data_out;
   end

   assign last_err = addr_bad | (par_q != data_out);
`else
   assign last_err = addr_bad;
`endif

   // Select what enters the buffer: header, returning byte, or abort marker
   always_comb begin
      buf_push  = 1'b0;
      buf_wdata = '0;
      if (state_q == HDR_WAIT) begin
         buf_push  = 1'b1;
         buf_wdata = {1'b0, 1'b1, 1'b0, data_out};
      end else if (rd_pend_q) begin
         buf_push  = 1'b1;
         buf_wdata = {last_pend_q, 1'b0, last_pend_q & last_err, data_out};
      end else if ((state_q == ABORT) && !buf_full) begin
         buf_push  = 1'b1;
         buf_wdata = {1'b1, 1'b0, 1'b1, {DATA_W{1'b0}}};
      end
   end

   router_reader_buf #(
      .W (BW)
   ) u_buf (
      .clock  (clock),
      .resetn (resetn),
      .push   (buf_push),
      .wdata  (buf_wdata),
      .pop    (buf_pop),
      .rdata  (buf_rdata),
      .full   (buf_full),
      .empty  (buf_empty),
      .count  (buf_cnt)
   );

   assign buf_pop  = m_ready & ~buf_empty;
   assign acc_last = buf_pop & buf_rdata[BW-1];

   assign m_valid = ~buf_empty;
   assign m_data  = buf_empty ? '0 : buf_rdata[DATA_W-1:0];
   assign m_err   = ~buf_empty & buf_rdata[DATA_W];
   assign m_first = ~buf_empty & buf_rdata[DATA_W+1];
   assign m_last  = ~buf_empty & buf_rdata[DATA_W+2];

   assign busy    = (state_q != IDLE);
   assign pkt_cnt = pkt_cnt_q;
   assign err_cnt = err_cnt_q;

   // Packet FSM with read bookkeeping, stall watchdog and packet counters
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         rd_left_q   <= 7'd0;
         rd_pend_q   <= 1'b0;
         last_pend_q <= 1'b0;
         stall_q     <= '0;
         addr_q      <= 2'b00;
         pkt_cnt_q   <= '0;
         err_cnt_q   <= 8'd0;
      end else begin
         rd_pend_q   <= read_enb;
         last_pend_q <= read_enb & (state_q == BODY) & (rd_left_q == 7'd1);
         case (state_q)
            IDLE: begin
               if (read_enb)
                  state_q <= HDR_WAIT;
            end
            HDR_WAIT: begin
               rd_left_q <= {1'b0, hdr_len(hdr)} + 7'd1;
               addr_q    <= hdr_addr(hdr);
               stall_q   <= '0;
               state_q   <= BODY;
            end
            BODY: begin
               if (read_enb) begin
                  rd_left_q <= rd_left_q - 7'd1;
                  stall_q   <= '0;
               end else if (!vld_out && (rd_left_q != 7'd0)) begin
                  stall_q <= stall_q + 1'b1;
                  if (stall_q + 1'b1 == SW'(STALL_MAX))
                     state_q <= ABORT;
               end
               if (rd_pend_q && last_pend_q)
                  state_q <= DRAIN;
            end
            ABORT: begin
               if (!rd_pend_q && !buf_full)
                  state_q <= DRAIN;
            end
            DRAIN: begin
               if (acc_last) begin
                  pkt_cnt_q <= pkt_cnt_q + 1'b1;
                  if (buf_rdata[DATA_W] && (err_cnt_q != 8'hFF))
                     err_cnt_q <= err_cnt_q + 8'd1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_router_port_reader.sv
// Directed bench for router_port_reader: behavioural port FIFO model,
// stream monitor, table of packet vectors plus stall-abort and reset cases.
module tb_router_port_reader;

`ifdef ROUTER_READER_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        resetn;
   logic        vld_out;
   logic [7:0]  data_out;
   logic        read_enb;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_first;
   logic        m_last;
   logic        m_err;
   logic        busy;
   logic [15:0] pkt_cnt;
   logic [7:0]  err_cnt;

   router_port_reader #(
      .DATA_W    (8),
      .PORT_ADDR (2'b00),
      .STALL_MAX (32),
      .CNT_W     (16)
   ) dut (
      .clock    (clock),
      .resetn   (resetn),
      .vld_out  (vld_out),
      .data_out (data_out),
      .read_enb (read_enb),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_first  (m_first),
      .m_last   (m_last),
      .m_err    (m_err),
      .busy     (busy),
      .pkt_cnt  (pkt_cnt),
      .err_cnt  (err_cnt)
   );

   always #5 clock = ~clock;

   logic [7:0]  fifo[$];
   logic [10:0] beats[$];      // {first, last, err, data} as accepted
   logic [10:0] exp_beats[$];
   int          rdy_mode;      // 0: ready high, 1: toggle, 2: low
   int          n_cmp = 0;
   int          n_bad = 0;
   int          exp_pkt = 0;
   int          exp_err = 0;

   typedef struct {
      int         len;
      logic [1:0] addr;
      bit         corrupt;
      int         rdy;
      bit         eerr;
   } vec_t;
   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Port FIFO model: read request seen before the edge returns data after it
   initial begin : drv
      logic re;
      vld_out  = 1'b0;
      data_out = 8'h00;
      m_ready  = 1'b1;
      forever begin
         @(negedge clock);
         re = read_enb;
         @(posedge clock);
         #1;
         if (re && fifo.size() > 0)
            data_out = fifo.pop_front();
         vld_out = (fifo.size() > 0);
         case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'b0;
         endcase
      end
   end

   // Stream monitor: record every accepted beat
   initial begin : mon
      forever begin
         @(negedge clock);
         if (resetn && m_valid && m_ready)
            beats.push_back({m_first, m_last, m_err, m_data});
      end
   end

   task automatic wait_beats(input int n, input int limit, input string name);
      int cyc;
      cyc = 0;
      while (beats.size() < n && cyc < limit) begin
         @(posedge clock);
         cyc++;
      end
      chk({name, "_beat_count"}, beats.size(), n);
   endtask

   task automatic cmp_beats(input string name);
      for (int i = 0; i < exp_beats.size(); i++) begin
         if (i < beats.size())
            chk($sformatf("%s_beat%0d", name, i), beats[i], exp_beats[i]);
      end
   endtask

   task automatic load_pkt(input int len, input logic [1:0] addr, input bit corrupt,
                           input bit eerr, input int seed);
      logic [7:0] h, b, par;
      h   = {6'(len), addr};
      par = h;
      fifo.push_back(h);
      exp_beats.push_back({1'b1, 1'b0, 1'b0, h});
      for (int i = 0; i < len; i++) begin
         b = 8'(i * 37 + seed * 11 + 5);
         par = par ^ b;
         fifo.push_back(b);
         exp_beats.push_back({1'b0, 1'b0, 1'b0, b});
      end
      b = corrupt ? (par ^ 8'h5A) : par;
      fifo.push_back(b);
      exp_beats.push_back({1'b0, 1'b1, eerr, b});
   endtask

   initial begin : main
      resetn   = 1'b0;
      rdy_mode = 0;
      vecs[0] = '{3,  2'b00, 1'b0, 0, 1'b0};
      vecs[1] = '{0,  2'b00, 1'b0, 0, 1'b0};
      vecs[2] = '{3,  2'b00, 1'b1, 0, PAR_EN};
      vecs[3] = '{2,  2'b01, 1'b0, 0, 1'b1};
      vecs[4] = '{10, 2'b00, 1'b0, 1, 1'b0};

      repeat (2) @(posedge clock);
      #2;
      chk("reset_outs", {read_enb, m_valid, m_data, m_first, m_last, m_err, busy}, 0);
      chk("reset_pkt_cnt", pkt_cnt, 0);
      chk("reset_err_cnt", err_cnt, 0);
      @(negedge clock);
      resetn = 1'b1;

      // Table-driven packets
      for (int v = 0; v < 5; v++) begin
         beats.delete();
         exp_beats.delete();
         rdy_mode = vecs[v].rdy;
         @(posedge clock);
         #2;
         load_pkt(vecs[v].len, vecs[v].addr, vecs[v].corrupt, vecs[v].eerr, v);
         exp_pkt++;
         if (vecs[v].eerr) exp_err++;
         wait_beats(vecs[v].len + 2, 1000, $sformatf("v%0d", v));
         cmp_beats($sformatf("v%0d", v));
         rdy_mode = 0;
         repeat (3) @(posedge clock);
         #2;
         chk($sformatf("v%0d_busy", v), busy, 0);
         chk($sformatf("v%0d_pkt_cnt", v), pkt_cnt, exp_pkt);
         chk($sformatf("v%0d_err_cnt", v), err_cnt, exp_err);
      end

      // Stall abort: len=5 but only 2 payload bytes ever arrive
      beats.delete();
      exp_beats.delete();
      @(posedge clock);
      #2;
      fifo.push_back({6'd5, 2'b00});
      fifo.push_back(8'hA1);
      fifo.push_back(8'hB2);
      exp_beats.push_back({1'b1, 1'b0, 1'b0, 8'h14});
      exp_beats.push_back({1'b0, 1'b0, 1'b0, 8'hA1});
      exp_beats.push_back({1'b0, 1'b0, 1'b0, 8'hB2});
      exp_beats.push_back({1'b0, 1'b1, 1'b1, 8'h00});
      repeat (15) @(posedge clock);
      #2;
      chk("stall_busy_mid", busy, 1);
      chk("stall_no_marker_yet", beats.size(), 3);
      wait_beats(4, 300, "stall");
      cmp_beats("stall");
      exp_pkt++;
      exp_err++;
      repeat (3) @(posedge clock);
      #2;
      chk("stall_busy", busy, 0);
      chk("stall_err_cnt", err_cnt, exp_err);
      chk("stall_pkt_cnt", pkt_cnt, exp_pkt);

      // Async reset in the middle of a packet
      beats.delete();
      exp_beats.delete();
      rdy_mode = 1;
      @(posedge clock);
      #2;
      load_pkt(10, 2'b00, 1'b0, 1'b0, 7);
      wait_beats(4, 200, "rst_pre");
      @(posedge clock);
      #2;
      chk("rst_pre_busy", busy, 1);
      resetn = 1'b0;
      #1;
      chk("rst_async_outs", {read_enb, m_valid, m_data, m_first, m_last, m_err, busy}, 0);
      chk("rst_async_pkt_cnt", pkt_cnt, 0);
      chk("rst_async_err_cnt", err_cnt, 0);
      fifo.delete();
      rdy_mode = 0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;
      repeat (3) @(posedge clock);
      #2;
      chk("rst_after_idle", {busy, m_valid, read_enb}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin : wdog
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/router_port_reader.md
Name: router_port_reader

Overview:
- Destination-side consumer for one router output port; one instance per port (0/1/2).
- Watches the port's vld_out, drives its read_enb, and pulls complete packets from the port FIFO: header, payload, parity.
- Re-emits each packet as a valid/ready byte stream with first/last/error markers; checks header address and length bookkeeping.
- Must start draining promptly enough to stay inside the router's 30-cycle soft-reset window.

Parameters:
- DATA_W, 8, FIFO/stream byte width (header layout fixed at 8).
- PORT_ADDR, 2'b00, expected header address bits [1:0] for this port.
- STALL_MAX, 32, consecutive vld_out-low cycles mid-packet before abort.
- CNT_W, 16, width of packet counter.

Ports:
- clock  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- vld_out  in  1  port FIFO non-empty.
- data_out  in  DATA_W  port FIFO read data; valid the cycle after read_enb is high.
- read_enb  out  1  FIFO pop request.
- m_data  out  DATA_W  stream byte.
- m_valid  out  1  stream beat valid.
- m_ready  in  1  downstream accept.
- m_first  out  1  beat is header.
- m_last  out  1  beat is parity byte or abort marker.
- m_err  out  1  error flag; meaningful only on m_last beats.
- busy  out  1  packet in progress (state != IDLE).
- pkt_cnt  out  CNT_W  packets completed, wraps.
- err_cnt  out  8  errored packets, saturates at 255.

Behaviour:
- Async reset (resetn low) clears all state. Outputs: read_enb=0, m_valid=0, m_data=0, m_first/m_last/m_err=0, busy=0, pkt_cnt=0, err_cnt=0. Buffer is emptied.
- Packet format: header = {len[7:2], addr[1:0]}, then len payload bytes, then one parity byte (XOR of header and all payload bytes). len=0 is legal: header is followed directly by parity.
- Output buffer:
  - 2-entry FIFO.
  - credit = free entries minus reads in flight (0 or 1).
  - read_enb is combinational: (state is IDLE or BODY) & vld_out & credit>=1 & (IDLE or rd_left>0).
  - A beat written on cycle N+1 from a read issued on N is visible at m_data no earlier than N+2.
- FSM states:
  - IDLE: on read_enb go to HDR_WAIT; header byte returns next cycle.
  - HDR_WAIT: capture header, push it with first=1, set rd_left=len+1, clear stall counter, go to BODY. No read issued in this cycle; a one-cycle bubble per packet is accepted.
  - BODY:
    - Issue reads while rd_left>0, decrementing on each read.
    - The returning byte whose read took rd_left 1->0 is pushed with last=1. Its err = addr!=PORT_ADDR, OR'd with parity mismatch when enabled.
    - When rd_left==0 and that read has returned, go to DRAIN.
    - Stall counter increments every BODY cycle with vld_out low and rd_left>0, and clears on any read.
    - At STALL_MAX go to ABORT.
  - DRAIN: when the last beat is accepted (m_valid&m_ready&m_last), increment pkt_cnt. Also increment err_cnt if m_err. Then go to IDLE.
  - ABORT:
    - Wait for any in-flight read to return.
    - Push one marker beat: m_data=0, last=1, err=1.
    - Go to DRAIN.
    - Late FIFO bytes after an abort are treated as a new packet header.
- Stream rules:
  - m_valid/m_data/markers hold stable while m_valid&!m_ready.
  - No beat is dropped or duplicated.
  - Push and pop in the same cycle are allowed with the buffer full.
- Backpressure: when m_ready is held low, reads stop. The router may then soft-reset the FIFO; vld_out falls, and the stall path yields an aborted packet. This is the intended recovery.
- Simultaneous: accept of the last beat in the same cycle vld_out rises for the next packet. The next header read is issued no earlier than the cycle after returning to IDLE.

Optional Feature:
- ROUTER_READER_PARITY_CHECK_EN defined:
  - Running XOR over header and payload.
  - Mismatch with the parity byte sets m_err on the last beat.
- Undefined:
  - No XOR logic.
  - m_err comes only from address mismatch or abort.
  - The parity byte is still forwarded unchanged.

Decomposition:
- Shared package router_pkg holds:
  - header field positions (LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1, ADDR_LSB=0);
  - the state enum {IDLE, HDR_WAIT, BODY, ABORT, DRAIN};
  - the SOFT_RESET_CYCLES=30 constant.
- One sub-module: router_reader_buf, the 2-entry buffer carrying {last, first, err, data} with full/empty/count outputs.

Test Plan:
- addr=PORT_ADDR, len=3, correct parity, m_ready=1 -> 5 beats in order, first on beat 0, last on beat 4, m_err=0, pkt_cnt=1.
- len=0 packet -> 2 beats (header with first=1, parity with last=1), m_err=0.
- Corrupted parity byte (PARITY_CHECK_EN defined) -> m_err=1 on last beat, err_cnt=1; with the macro undefined -> m_err=0.
- Header addr!=PORT_ADDR -> packet fully forwarded, last beat m_err=1.
- vld_out dropped after 2 payload bytes of len=5 for 32 cycles -> marker beat data=0, last=1, err=1; err_cnt=1; busy returns to 0.
- m_ready toggling 1/0 every cycle on len=10 -> all 12 bytes delivered intact. Then resetn pulsed low mid-packet -> all outputs 0 immediately, without waiting for a clock edge.
